// File: rtl/counter_mod_trig_pkg.sv
// Shared types and constants for counter_mod_trig and its trigger generator.
// Down-counting is enabled by defining COUNTER_MOD_TRIG_DOWN_EN.
package counter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } cnt_state_t;

    localparam logic CNT_UP   = 1'b0;
    localparam logic CNT_DOWN = 1'b1;

endpackage

// File: rtl/counter_mod_trig_if.sv
// Control and status bundle for counter_mod_trig; master drives controls, slave is the counter.
// Down-counting (dir) is honoured only when COUNTER_MOD_TRIG_DOWN_EN is defined.
interface counter_mod_trig_if #(
    parameter int WIDTH = 8
);
    logic             n_en;
    logic             start;
    logic             oneshot;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] modulus;
    logic             dir;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] trig_out;
    logic             tc;
    logic             busy;

    modport master (
        output n_en, start, oneshot, load, load_val, modulus, dir,
        input  count, trig_out, tc, busy
    );

    modport slave (
        input  n_en, start, oneshot, load, load_val, modulus, dir,
        output count, trig_out, tc, busy
    );
endinterface

// File: rtl/counter_trig_gen.sv
// Per-bit carry (up) / borrow (down) triggers from the pre-step count, gated by advance.
// Borrow chain exists only when COUNTER_MOD_TRIG_DOWN_EN is defined.
module counter_trig_gen #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] count,
    input  logic             advance,
    input  logic             down,
    output logic [WIDTH-1:0] trig
);
    logic [WIDTH-1:0] ones_pre;
`ifdef COUNTER_MOD_TRIG_DOWN_EN
    logic [WIDTH-1:0] zeros_pre;
`else
    logic unused_down;
    assign unused_down = down;
`endif

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            if (gi == 0) begin : g_lsb
                assign ones_pre[gi] = count[gi];
`ifdef COUNTER_MOD_TRIG_DOWN_EN
                assign zeros_pre[gi] = ~count[gi];
`endif
            end else begin : g_chain
                assign ones_pre[gi] = ones_pre[gi-1] & count[gi];
`ifdef COUNTER_MOD_TRIG_DOWN_EN
                assign zeros_pre[gi] = zeros_pre[gi-1] & ~count[gi];
`endif
            end
`ifdef COUNTER_MOD_TRIG_DOWN_EN
            assign trig[gi] = advance & (down ? zeros_pre[gi] : ones_pre[gi]);
`else
            assign trig[gi] = advance & ones_pre[gi];
`endif
        end
    endgenerate
endmodule

// File: rtl/counter_mod_trig.sv
// Modulus counter with load, one-shot/free-run FSM, terminal-count pulse and per-bit triggers.
// Define COUNTER_MOD_TRIG_DOWN_EN to let dir select down-counting.
module counter_mod_trig
    import counter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    counter_mod_trig_if.slave  bus
);
    cnt_state_t       state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] trig_out_q, trig_out_d;
    logic             tc_q, tc_d;
    logic             advance;
    logic             down_step;
    logic             terminal;

`ifdef COUNTER_MOD_TRIG_DOWN_EN
    assign down_step = (bus.dir == CNT_DOWN);
`else
    logic unused_dir;
    assign unused_dir = bus.dir;
    assign down_step  = 1'b0;
`endif

    // load and start both pre-empt a step, which also silences triggers and tc
    assign advance = (state_q == RUN) && !bus.n_en && !bus.load && !bus.start;

    counter_trig_gen #(.WIDTH(WIDTH)) u_trig_gen (
        .count   (count_q),
        .advance (advance),
        .down    (down_step),
        .trig    (trig_out_d)
    );

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        terminal = 1'b0;
        if (bus.load) begin
            count_d = bus.load_val;
        end else if (bus.start) begin
            count_d = '0;
            state_d = RUN;
        end else if (advance) begin
            if (down_step) begin
`ifdef COUNTER_MOD_TRIG_DOWN_EN
                if (count_q == '0) begin
                    count_d  = bus.modulus;
                    terminal = 1'b1;
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
`endif
            end else if (count_q == bus.modulus) begin
                count_d  = '0;
                terminal = 1'b1;
            end else begin
                // Wrap past all-ones is plain binary overflow, not a terminal step
                count_d = count_q + WIDTH'(1);
            end
            if (terminal && bus.oneshot) begin
                state_d = IDLE;
            end
        end
        tc_d = terminal;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            count_q    <= '0;
            trig_out_q <= '0;
            tc_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            trig_out_q <= trig_out_d;
            tc_q       <= tc_d;
        end
    end

    assign bus.count    = count_q;
    assign bus.trig_out = trig_out_q;
    assign bus.tc       = tc_q;
    assign bus.busy     = (state_q == RUN);
endmodule

// File: tb/tb_counter_mod_trig.sv
// Scoreboard bench for counter_mod_trig: stimulus queues hand-computed expectations per cycle,
// a monitor pops and compares them just after each rising edge.
module tb_counter_mod_trig;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    counter_mod_trig_if #(.WIDTH(8)) bus ();

    counter_mod_trig #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        int         cyc;
        logic [7:0] cnt;
        logic [7:0] trig;
        logic       tc;
        logic       busy;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   cyc_cnt    = 0;
    int   total_cnt  = 0;
    int   pass_cnt   = 0;
    int   txn_cnt    = 0;

    task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s txn %0d: got %02h expected %02h", nm, idx, act, req);
    endtask

    // Monitor: compares every expectation due at this edge
    always @(posedge clk) begin
        cyc_cnt++;
        #2;
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc_cnt) begin
            mon_e = exp_q.pop_front();
            txn_cnt++;
            if (mon_e.cyc < cyc_cnt) begin
                total_cnt++;
                $display("FAIL missed txn %0d: due cycle %0d, now %0d", txn_cnt, mon_e.cyc, cyc_cnt);
            end else begin
                $display("txn %0d cyc %0d: count=%02h trig=%02h tc=%0b busy=%0b", txn_cnt, cyc_cnt,
                         bus.count, bus.trig_out, bus.tc, bus.busy);
                chk("count", txn_cnt, bus.count, mon_e.cnt);
                chk("trig_out", txn_cnt, bus.trig_out, mon_e.trig);
                chk("tc", txn_cnt, {7'd0, bus.tc}, {7'd0, mon_e.tc});
                chk("busy", txn_cnt, {7'd0, bus.busy}, {7'd0, mon_e.busy});
            end
        end
    end

    // Drive one cycle from a falling edge and queue what the next rising edge must produce
    task automatic cyc(input logic n, input logic st, input logic ld, input logic [7:0] lv,
                       input logic [7:0] ec, input logic [7:0] et, input logic etc, input logic eb);
        exp_t e;
        bus.n_en     = n;
        bus.start    = st;
        bus.load     = ld;
        bus.load_val = lv;
        e.cyc  = cyc_cnt + 1;
        e.cnt  = ec;
        e.trig = et;
        e.tc   = etc;
        e.busy = eb;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle_cyc();
        bus.n_en  = 1'b1;
        bus.start = 1'b0;
        bus.load  = 1'b0;
        @(negedge clk);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() > 0) begin
            total_cnt++;
            $display("FAIL drain: %0d expectations never compared, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    logic [7:0] f_cnt [12] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h00, 8'h01, 8'h02};
    logic [7:0] f_trig[12] = '{8'h00, 8'h01, 8'h00, 8'h03, 8'h00, 8'h01, 8'h00, 8'h07, 8'h00, 8'h01, 8'h00, 8'h01};
`ifdef COUNTER_MOD_TRIG_DOWN_EN
    logic [7:0] d_cnt [6] = '{8'h04, 8'h03, 8'h02, 8'h01, 8'h00, 8'h04};
    logic [7:0] d_trig[6] = '{8'hFF, 8'h03, 8'h00, 8'h01, 8'h00, 8'hFF};
    logic       d_tc  [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`else
    logic [7:0] d_cnt [6] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h01};
    logic [7:0] d_trig[6] = '{8'h00, 8'h01, 8'h00, 8'h03, 8'h00, 8'h00};
    logic       d_tc  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
`endif

    initial begin
        bus.n_en     = 1'b1;
        bus.start    = 1'b0;
        bus.oneshot  = 1'b0;
        bus.load     = 1'b0;
        bus.load_val = 8'h00;
        bus.modulus  = 8'd9;
        bus.dir      = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Out of reset: IDLE, n_en low alone does not count
        cyc(0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0);
        cyc(0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0);

        // Free-run, modulus 9
        cyc(1, 1, 0, 8'h00, 8'h00, 8'h00, 0, 1);
        for (int i = 0; i < 12; i++)
            cyc(0, 0, 0, 8'h00, f_cnt[i], f_trig[i], (i == 9), 1);

        // One-shot, modulus 3
        bus.oneshot = 1'b1;
        bus.modulus = 8'd3;
        cyc(1, 1, 0, 8'h00, 8'h00, 8'h00, 0, 1);
        cyc(0, 0, 0, 8'h00, 8'h01, 8'h00, 0, 1);
        cyc(0, 0, 0, 8'h00, 8'h02, 8'h01, 0, 1);
        cyc(0, 0, 0, 8'h00, 8'h03, 8'h00, 0, 1);
        cyc(0, 0, 0, 8'h00, 8'h00, 8'h03, 1, 0);
        for (int i = 0; i < 3; i++)
            cyc(0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0);
        cyc(1, 1, 0, 8'h00, 8'h00, 8'h00, 0, 1);

        // Load while advancing, then load+start together
        bus.oneshot = 1'b0;
        bus.modulus = 8'hFF;
        cyc(0, 0, 0, 8'h00, 8'h01, 8'h00, 0, 1);
        cyc(0, 0, 1, 8'h0F, 8'h0F, 8'h00, 0, 1);
        cyc(0, 0, 0, 8'h00, 8'h10, 8'h0F, 0, 1);
        cyc(0, 1, 1, 8'h33, 8'h33, 8'h00, 0, 1);
        cyc(0, 0, 0, 8'h00, 8'h34, 8'h03, 0, 1);

        // Loaded above modulus: binary wrap through all-ones, no tc
        bus.modulus = 8'h10;
        cyc(1, 0, 1, 8'hFE, 8'hFE, 8'h00, 0, 1);
        cyc(0, 0, 0, 8'h00, 8'hFF, 8'h00, 0, 1);
        cyc(0, 0, 0, 8'h00, 8'h00, 8'hFF, 0, 1);
        cyc(0, 0, 0, 8'h00, 8'h01, 8'h00, 0, 1);

        // Modulus 0: every advance terminal
        bus.modulus = 8'h00;
        cyc(1, 1, 0, 8'h00, 8'h00, 8'h00, 0, 1);
        cyc(0, 0, 0, 8'h00, 8'h00, 8'h00, 1, 1);
        cyc(0, 0, 0, 8'h00, 8'h00, 8'h00, 1, 1);
        cyc(1, 0, 0, 8'h00, 8'h00, 8'h00, 0, 1);

        // dir=1, modulus 4 (up-only build ignores dir)
        bus.modulus = 8'd4;
        bus.dir     = 1'b1;
        cyc(1, 1, 0, 8'h00, 8'h00, 8'h00, 0, 1);
        for (int i = 0; i < 6; i++)
            cyc(0, 0, 0, 8'h00, d_cnt[i], d_trig[i], d_tc[i], 1);
        bus.dir = 1'b0;

        // Async reset mid-run at count 5
        bus.modulus = 8'd9;
        cyc(1, 1, 0, 8'h00, 8'h00, 8'h00, 0, 1);
        cyc(0, 0, 0, 8'h00, 8'h01, 8'h00, 0, 1);
        cyc(0, 0, 0, 8'h00, 8'h02, 8'h01, 0, 1);
        cyc(0, 0, 0, 8'h00, 8'h03, 8'h00, 0, 1);
        cyc(0, 0, 0, 8'h00, 8'h04, 8'h03, 0, 1);
        cyc(0, 0, 0, 8'h00, 8'h05, 8'h00, 0, 1);
        drain();
        #2;
        rst = 1'b1;
        #1;
        chk("rst_count", 0, bus.count, 8'h00);
        chk("rst_trig", 0, bus.trig_out, 8'h00);
        chk("rst_tc", 0, {7'd0, bus.tc}, 8'h00);
        chk("rst_busy", 0, {7'd0, bus.busy}, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++)
            cyc(0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0);
        idle_cyc();
        drain();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, required finish before 100000");
        $fatal(1, "timeout");
    end
endmodule
